gpio_ctrl: RTL and testbench
============================

Name: gpio_ctrl

Overview:
Parametrised general-purpose I/O controller that replaces ad-hoc per-pin LED/IRQ tri-state logic with a register-mapped block. It provides WIDTH pins, each with independent output value, output enable, open-drain mode, input synchroniser and rising/falling-edge interrupt capture. The block sits in cpu_soc on the CPU register bus. Its pad-side signals go to top-level tri-state buffers and loop back as pad_i.

Parameters:
WIDTH, 8, number of GPIO pins (1..32)
SYNC_STAGES, 2, input synchroniser depth (2..4)
RESET_OUT, '0, reset value of OUT register (WIDTH bits)
RESET_OE, '0, reset value of OE register (WIDTH bits)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
reg_addr  in  3  register select
reg_wdata  in  WIDTH  write data
reg_write  in  1  write strobe, one cycle per access
reg_read  in  1  read strobe, one cycle per access
reg_rdata  out  WIDTH  read data, valid the cycle after reg_read
pad_i  in  WIDTH  pin levels from pads (asynchronous)
pad_o  out  WIDTH  pin drive value
pad_oe  out  WIDTH  pin drive enable (1 = drive)
irq  out  1  level interrupt, high while any pending bit is set

Behaviour:
- Register map:
  - 0 OUT (RW)
  - 1 OE (RW)
  - 2 IN (RO, synchronised pin levels)
  - 3 OD (RW, open-drain mask)
  - 4 RISE_EN (RW)
  - 5 FALL_EN (RW)
  - 6 PENDING (read; write-1-to-clear)
  - 7 TOGGLE (write-only: OUT <= OUT ^ wdata; reads return 0)
- Writes to IN are ignored.
- Reset (async assert, sync to clk edge on release):
  - OUT=RESET_OUT, OE=RESET_OE; OD, RISE_EN, FALL_EN and PENDING = 0.
  - Synchroniser chain and in_prev = 0.
  - reg_rdata=0, irq=0.
- Pad drive, combinational from registers:
  - OD bit 0: pad_o=OUT, pad_oe=OE.
  - OD bit 1: pad_o=0, pad_oe=OE & ~OUT. The pin drives low or floats and never drives high.
- Write latency: a register written at clock edge k affects pad_o/pad_oe immediately after edge k.
- Read:
  - reg_read at edge k puts the register value into reg_rdata after edge k.
  - reg_rdata holds until the next read.
  - If read and write hit the same address in the same cycle, the read returns the pre-write value.
- Input path:
  - pad_i is sampled through SYNC_STAGES flops to give in_sync.
  - in_prev <= in_sync every cycle.
  - rise = in_sync & ~in_prev; fall = ~in_sync & in_prev.
- Timing from a pin stable before edge k:
  - IN reflects it after edge k+SYNC_STAGES-1.
  - The PENDING bit sets after edge k+SYNC_STAGES.
  - irq asserts after edge k+SYNC_STAGES+1 (irq is registered: irq <= |PENDING).
- Pending update per bit: PENDING <= (PENDING & ~clr) | (rise & RISE_EN) | (fall & FALL_EN), where clr = wdata when writing addr 6.
  - A set in the same cycle as a clear wins; the bit stays 1.
  - Enabling RISE_EN while a pin is already high does not set pending. Only edges set pending.
- Pins with OE=1 still synchronise and capture edges, so driven outputs are observable as input (loopback).
- Bits above WIDTH on the bus are not present. Addresses are fully decoded, all 8 in use.
- Reset mid-operation clears pending and irq immediately (asynchronously). Synchroniser history is lost. A pin high during reset release produces a rise at SYNC_STAGES cycles after release; it only sets pending if RISE_EN has been written to 1 by then.

Test Plan:
1. Reset with RESET_OE=8'h03, RESET_OUT=8'h01 -> pad_oe=03, pad_o=01, irq=0, all reads 0 except OUT=01, OE=03.
2. Write OD=8'h01, OE=8'h01; OUT=1 -> pad_oe[0]=0; OUT=0 -> pad_oe[0]=1, pad_o[0]=0; TOGGLE 8'h01 twice -> OUT returns to original.
3. RISE_EN=8'h04; pad_i[2] 0->1 before edge k (SYNC_STAGES=2) -> IN[2]=1 after k+1, PENDING=04 after k+2, irq=1 after k+3; falling edge with FALL_EN=0 -> no change.
4. Write PENDING=04 in the same cycle a new rise on pin 2 sets it -> PENDING stays 04, irq stays 1; clear in a quiet cycle -> PENDING=00, irq=0 one cycle later.
5. Simultaneous read and write of OUT (old 8'hAA, new 8'h55) -> reg_rdata=AA; next read returns 55.
6. Assert reset_n low while PENDING=FF and irq=1 -> irq and PENDING 0 without a clock edge; after release, a pin held high with RISE_EN=0 leaves PENDING=0.

Source files
------------

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: register-mapped GPIO block with per-pin output value, output enable,
//    open-drain mode, input synchroniser and rising/falling-edge interrupt capture.
// Latency: a write is visible on pad_o/pad_oe right after its clock edge; reg_rdata
//    is valid the cycle after reg_read; pin-to-irq is SYNC_STAGES+1 edges.
// Backpressure: none; the register bus accepts one read and/or one write per cycle.
// Ports: clk/reset_n (async active-low), reg_addr/reg_wdata/reg_write/reg_read/reg_rdata
//    register bus, pad_i/pad_o/pad_oe pad side, irq level interrupt.
module gpio_ctrl #(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] RESET_OUT   = '0,
   parameter logic [WIDTH-1:0] RESET_OE    = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       reg_addr,
   input  logic [WIDTH-1:0] reg_wdata,
   input  logic             reg_write,
   input  logic             reg_read,
   output logic [WIDTH-1:0] reg_rdata,
   input  logic [WIDTH-1:0] pad_i,
   output logic [WIDTH-1:0] pad_o,
   output logic [WIDTH-1:0] pad_oe,
   output logic             irq
);

   localparam logic [2:0] ADDR_OUT    = 3'd0;
   localparam logic [2:0] ADDR_OE     = 3'd1;
   localparam logic [2:0] ADDR_IN     = 3'd2;
   localparam logic [2:0] ADDR_OD     = 3'd3;
   localparam logic [2:0] ADDR_RISE   = 3'd4;
   localparam logic [2:0] ADDR_FALL   = 3'd5;
   localparam logic [2:0] ADDR_PEND   = 3'd6;
   localparam logic [2:0] ADDR_TOGGLE = 3'd7;

   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] oe_q, oe_d;
   logic [WIDTH-1:0] od_q, od_d;
   logic [WIDTH-1:0] rise_en_q, rise_en_d;
   logic [WIDTH-1:0] fall_en_q, fall_en_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             irq_q, irq_d;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [WIDTH-1:0] in_prev_q, in_prev_d;

   logic [WIDTH-1:0] in_sync;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] clr;

   assign in_sync = sync_q[SYNC_STAGES-1];
   assign rise    = in_sync & ~in_prev_q;
   assign fall    = ~in_sync & in_prev_q;

   always_comb begin
      out_d     = out_q;
      oe_d      = oe_q;
      od_d      = od_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      clr       = '0;
      if (reg_write) begin
         case (reg_addr)
            ADDR_OUT:    out_d     = reg_wdata;
            ADDR_OE:     oe_d      = reg_wdata;
            ADDR_OD:     od_d      = reg_wdata;
            ADDR_RISE:   rise_en_d = reg_wdata;
            ADDR_FALL:   fall_en_d = reg_wdata;
            ADDR_PEND:   clr       = reg_wdata;
            ADDR_TOGGLE: out_d     = out_q ^ reg_wdata;
            default:     ;  // IN is read-only
         endcase
      end

      // Clear is applied first so a same-cycle edge keeps the bit set.
      pend_d    = (pend_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
      irq_d     = |pend_q;
      in_prev_d = in_sync;

      sync_d[0] = pad_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end

      // Read mux uses the pre-write register values, so read-during-write
      // of the same address returns the old contents.
      rdata_d = rdata_q;
      if (reg_read) begin
         case (reg_addr)
            ADDR_OUT:  rdata_d = out_q;
            ADDR_OE:   rdata_d = oe_q;
            ADDR_IN:   rdata_d = in_sync;
            ADDR_OD:   rdata_d = od_q;
            ADDR_RISE: rdata_d = rise_en_q;
            ADDR_FALL: rdata_d = fall_en_q;
            ADDR_PEND: rdata_d = pend_q;
            default:   rdata_d = '0;  // TOGGLE is write-only
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q     <= RESET_OUT;
         oe_q      <= RESET_OE;
         od_q      <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         pend_q    <= '0;
         rdata_q   <= '0;
         irq_q     <= 1'b0;
         in_prev_q <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         out_q     <= out_d;
         oe_q      <= oe_d;
         od_q      <= od_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         pend_q    <= pend_d;
         rdata_q   <= rdata_d;
         irq_q     <= irq_d;
         in_prev_q <= in_prev_d;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
      end
   end

   // Open-drain pins only ever pull low: drive 0 when OUT=0, float when OUT=1.
   assign pad_o     = out_q & ~od_q;
   assign pad_oe    = oe_q & ~(od_q & out_q);
   assign reg_rdata = rdata_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
module tb_gpio_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_write;
   logic       reg_read;
   logic [7:0] reg_rdata;
   logic [7:0] pad_i;
   logic [7:0] pad_o;
   logic [7:0] pad_oe;
   logic       irq;

   int checks   = 0;
   int failures = 0;

   // Scoreboard: expected read data is queued when the read is issued and
   // popped when reg_rdata becomes valid.
   logic [7:0] exp_q [$];
   logic [7:0] exp_v;

   always #5 clk = ~clk;

   gpio_ctrl #(
      .WIDTH(8), .SYNC_STAGES(2), .RESET_OUT(8'h01), .RESET_OE(8'h03)
   ) dut (
      .clk(clk), .reset_n(reset_n), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_write(reg_write), .reg_read(reg_read), .reg_rdata(reg_rdata),
      .pad_i(pad_i), .pad_o(pad_o), .pad_oe(pad_oe), .irq(irq)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
      reg_addr  = a;
      reg_wdata = d;
      reg_write = 1'b1;
      tick();
      reg_write = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [7:0] e);
      exp_q.push_back(e);
      reg_addr = a;
      reg_read = 1'b1;
      tick();
      reg_read = 1'b0;
   endtask

   task automatic test_reset;
      logic [7:0] exp_regs [8];
      exp_regs = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      checks++;
      if (pad_oe !== 8'h03 || pad_o !== 8'h01 || irq !== 1'b0 || reg_rdata !== 8'h00) begin
         failures++;
         $display("FAIL reset_outputs: pad_oe=%h pad_o=%h irq=%b rdata=%h, want 03 01 0 00",
                  pad_oe, pad_o, irq, reg_rdata);
      end
      for (int a = 0; a < 8; a++) begin
         bus_read(3'(a), exp_regs[a]);
         exp_v = exp_q.pop_front();
         checks++;
         if (reg_rdata !== exp_v) begin
            failures++;
            $display("FAIL reset_read[%0d]: got %h want %h", a, reg_rdata, exp_v);
         end
      end
   endtask

   task automatic test_open_drain;
      logic [7:0] wr_addr [6];
      logic [7:0] wr_data [6];
      logic [7:0] want_oe [6];
      logic [7:0] want_o  [6];
      // OD, OE, OUT=0, TOGGLE, TOGGLE, then OD off with OUT=05
      wr_addr = '{8'd3, 8'd1, 8'd0, 8'd7, 8'd7, 8'd3};
      wr_data = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00};
      want_oe = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01};
      want_o  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 6; i++) begin
         bus_write(wr_addr[i][2:0], wr_data[i]);
         checks++;
         if (pad_oe !== want_oe[i] || pad_o !== want_o[i]) begin
            failures++;
            $display("FAIL od_step[%0d]: pad_oe=%h pad_o=%h want %h %h",
                     i, pad_oe, pad_o, want_oe[i], want_o[i]);
         end
      end
      bus_read(3'd0, 8'h00);
      exp_v = exp_q.pop_front();
      checks++;
      if (reg_rdata !== exp_v) begin
         failures++;
         $display("FAIL toggle_restore: got %h want %h", reg_rdata, exp_v);
      end
      bus_read(3'd7, 8'h00);
      exp_v = exp_q.pop_front();
      checks++;
      if (reg_rdata !== exp_v) begin
         failures++;
         $display("FAIL toggle_read: got %h want %h", reg_rdata, exp_v);
      end
      bus_write(3'd0, 8'h05);
      checks++;
      if (pad_o !== 8'h05 || pad_oe !== 8'h01) begin
         failures++;
         $display("FAIL push_pull: pad_o=%h pad_oe=%h want 05 01", pad_o, pad_oe);
      end
   endtask

   task automatic test_rise_irq;
      bus_write(3'd4, 8'h04);
      pad_i = 8'h04;           // stable before edge k
      tick();                  // edge k
      bus_read(3'd2, 8'h00);   // edge k+1 samples IN before it updates
      exp_v = exp_q.pop_front();
      checks++;
      if (reg_rdata !== exp_v) begin
         failures++;
         $display("FAIL in_early: got %h want %h", reg_rdata, exp_v);
      end
      bus_read(3'd2, 8'h04);   // edge k+2 sees IN after k+1
      exp_v = exp_q.pop_front();
      checks++;
      if (reg_rdata !== exp_v) begin
         failures++;
         $display("FAIL in_sync: got %h want %h", reg_rdata, exp_v);
      end
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL irq_early: got %b want 0", irq);
      end
      bus_read(3'd6, 8'h04);   // edge k+3 sees PENDING after k+2
      exp_v = exp_q.pop_front();
      checks++;
      if (reg_rdata !== exp_v) begin
         failures++;
         $display("FAIL pend_rise: got %h want %h", reg_rdata, exp_v);
      end
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL irq_rise: got %b want 1", irq);
      end
      pad_i = 8'h00;           // falling edge with FALL_EN=0
      for (int i = 0; i < 5; i++) tick();
      bus_read(3'd6, 8'h04);
      exp_v = exp_q.pop_front();
      checks++;
      if (reg_rdata !== exp_v || irq !== 1'b1) begin
         failures++;
         $display("FAIL fall_ignored: pend=%h irq=%b want %h 1", reg_rdata, irq, exp_v);
      end
   endtask

   task automatic test_clear_race;
      pad_i = 8'h04;
      tick();                  // edge k
      tick();                  // edge k+1
      bus_write(3'd6, 8'h04);  // clear at k+2, same edge the rise sets
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL race_irq: got %b want 1", irq);
      end
      bus_read(3'd6, 8'h04);
      exp_v = exp_q.pop_front();
      checks++;
      if (reg_rdata !== exp_v || irq !== 1'b1) begin
         failures++;
         $display("FAIL race_pend: pend=%h irq=%b want %h 1", reg_rdata, irq, exp_v);
      end
      bus_write(3'd6, 8'h04);  // quiet clear
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL clr_irq_lag: got %b want 1", irq);
      end
      tick();
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL clr_irq: got %b want 0", irq);
      end
      bus_read(3'd6, 8'h00);
      exp_v = exp_q.pop_front();
      checks++;
      if (reg_rdata !== exp_v) begin
         failures++;
         $display("FAIL clr_pend: got %h want %h", reg_rdata, exp_v);
      end
   endtask

   task automatic test_back_to_back;
      bus_write(3'd0, 8'hAA);
      exp_q.push_back(8'hAA);
      reg_addr  = 3'd0;
      reg_wdata = 8'h55;
      reg_write = 1'b1;
      reg_read  = 1'b1;
      tick();
      reg_write = 1'b0;
      reg_read  = 1'b0;
      exp_v = exp_q.pop_front();
      checks++;
      if (reg_rdata !== exp_v || pad_o !== 8'h55) begin
         failures++;
         $display("FAIL rw_same: rdata=%h pad_o=%h want %h 55", reg_rdata, pad_o, exp_v);
      end
      bus_read(3'd0, 8'h55);
      exp_v = exp_q.pop_front();
      checks++;
      if (reg_rdata !== exp_v) begin
         failures++;
         $display("FAIL rw_after: got %h want %h", reg_rdata, exp_v);
      end
   endtask

   task automatic test_async_reset;
      pad_i = 8'h00;
      for (int i = 0; i < 4; i++) tick();
      bus_write(3'd4, 8'hFF);
      pad_i = 8'hFF;
      for (int i = 0; i < 4; i++) tick();
      bus_read(3'd6, 8'hFF);
      exp_v = exp_q.pop_front();
      checks++;
      if (reg_rdata !== exp_v || irq !== 1'b1) begin
         failures++;
         $display("FAIL pend_all: pend=%h irq=%b want %h 1", reg_rdata, irq, exp_v);
      end
      reset_n = 1'b0;
      #2;                      // no clock edge in between
      checks++;
      if (irq !== 1'b0 || reg_rdata !== 8'h00 || pad_oe !== 8'h03) begin
         failures++;
         $display("FAIL async_clear: irq=%b rdata=%h pad_oe=%h want 0 00 03",
                  irq, reg_rdata, pad_oe);
      end
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      bus_read(3'd6, 8'h00);
      exp_v = exp_q.pop_front();
      checks++;
      if (reg_rdata !== exp_v || irq !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_pend: pend=%h irq=%b want %h 0", reg_rdata, irq, exp_v);
      end
      bus_read(3'd2, 8'hFF);
      exp_v = exp_q.pop_front();
      checks++;
      if (reg_rdata !== exp_v) begin
         failures++;
         $display("FAIL post_reset_in: got %h want %h", reg_rdata, exp_v);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      reg_addr  = 3'd0;
      reg_wdata = 8'h00;
      reg_write = 1'b0;
      reg_read  = 1'b0;
      pad_i     = 8'h00;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      test_reset();
      test_open_drain();
      test_rise_irq();
      test_clear_race();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
